antares_muldiv_unit: RTL

Multi-cycle multiply/divide unit with the architectural HI/LO registers, located in the EX stage directly downstream of the ID→EX pipeline register. It consumes the EX-stage operands (`ex_data_rs`, `ex_data_rt`) and a decoded mul/div operation, and runs MULT(U), MADD(U), MSUB(U), DIV(U), MTHI and MTLO. While an operation is in flight it raises a stall request toward the hazard logic so that dependent instructions (a new mul/div op, MFHI or MFLO) wait in EX.

---
 rtl/antares_muldiv_unit.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/antares_muldiv_unit.sv
// antares_muldiv_unit
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Multiplies run through a three-stage registered pipeline (partial products,
// product sum, accumulate/write); divides use a 32-step restoring loop on
// operand magnitudes followed by a single sign-fix cycle. While an operation
// is in flight, any dependent EX instruction (new mul/div op, MFHI, MFLO) is
// held by ex_muldiv_stall.

module antares_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ex_muldiv_op,
  input  logic [31:0] ex_data_rs,
  input  logic [31:0] ex_data_rt,
  input  logic        ex_read_hilo,
  input  logic        ex_stall,
  input  logic        ex_flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        muldiv_busy,
  output logic        ex_muldiv_stall
);

  // Operation encodings; codes 11..15 decode as NONE.
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  // Counter reload values: three multiply edges, 32 divide steps plus sign fix.
  localparam logic [5:0] MUL_CYCLES = 6'd3;
  localparam logic [5:0] DIV_CYCLES = 6'd33;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } stateT;

  stateT       state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] opA_q, opA_d;
  logic [31:0] opB_q, opB_d;
  logic [63:0] ppLow_q, ppLow_d;
  logic [31:0] ppCross_q, ppCross_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] divQuo_q, divQuo_d;
  logic [31:0] divRem_q, divRem_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        opValid;
  logic        accept;
  logic        newDivSigned;
  logic        mulSigned;
  logic [31:0] mulAHi;
  logic [31:0] mulBHi;
  logic [63:0] hiLoNow;
  logic [63:0] mulResult;
  logic [32:0] divShift;
  logic [32:0] divTrial;
  logic        quoNegate;
  logic        remNegate;
  logic [31:0] quoFixed;
  logic [31:0] remFixed;

  // Request decode and acceptance: only a valid op in IDLE with EX free to advance.
  assign opValid      = (ex_muldiv_op != OP_NONE) && (ex_muldiv_op <= OP_MTLO);
  assign accept       = (state_q == S_IDLE) && opValid && !ex_stall && !ex_flush;
  assign newDivSigned = (ex_muldiv_op == OP_DIV);

  // Signed multiplies sign-extend to 64 bits; only the upper extension words differ.
  assign mulSigned = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign mulAHi    = {32{mulSigned & opA_q[31]}};
  assign mulBHi    = {32{mulSigned & opB_q[31]}};

  // HI/LO is read at the final multiply edge, so MADD/MSUB see the latest value.
  assign hiLoNow   = {hi_q, lo_q};
  assign mulResult = ((op_q == OP_MADD) || (op_q == OP_MADDU)) ? (hiLoNow + prod_q) :
                     ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) ? (hiLoNow - prod_q) :
                     prod_q;

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  assign divShift = {divRem_q, divQuo_q[31]};
  assign divTrial = divShift - {1'b0, divisor_q};

  // Sign fix for DIV: quotient negative when operand signs differ, remainder follows rs.
  assign quoNegate = (op_q == OP_DIV) && (opA_q[31] ^ opB_q[31]);
  assign remNegate = (op_q == OP_DIV) && opA_q[31];
  assign quoFixed  = quoNegate ? (32'd0 - divQuo_q) : divQuo_q;
  assign remFixed  = remNegate ? (32'd0 - divRem_q) : divRem_q;

  // Next-state logic for the FSM and all datapath registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    ppLow_d   = ppLow_q;
    ppCross_d = ppCross_q;
    prod_d    = prod_q;
    divQuo_d  = divQuo_q;
    divRem_d  = divRem_q;
    divisor_d = divisor_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = ex_muldiv_op;
          opA_d = ex_data_rs;
          opB_d = ex_data_rt;
          case (ex_muldiv_op)
            OP_MTHI: hi_d = ex_data_rs;
            OP_MTLO: lo_d = ex_data_rs;
            OP_DIV, OP_DIVU: begin
              state_d   = S_DIV;
              cnt_d     = DIV_CYCLES;
              divRem_d  = 32'd0;
              divQuo_d  = (newDivSigned && ex_data_rs[31]) ? (32'd0 - ex_data_rs) : ex_data_rs;
              divisor_d = (newDivSigned && ex_data_rt[31]) ? (32'd0 - ex_data_rt) : ex_data_rt;
            end
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              state_d = S_MUL;
              cnt_d   = MUL_CYCLES;
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == MUL_CYCLES) begin
          // Stage 1: low product and the cross terms that land in the upper word.
          ppLow_d   = 64'(opA_q) * 64'(opB_q);
          ppCross_d = (mulAHi * opB_q) + (opA_q * mulBHi);
        end else if (cnt_q == 6'd2) begin
          // Stage 2: combine into the 64-bit product (modulo 2^64).
          prod_d = ppLow_q + {ppCross_q, 32'd0};
        end else begin
          // Stage 3: write or accumulate into HI/LO and release the pipeline.
          {hi_d, lo_d} = mulResult;
          state_d      = S_IDLE;
        end
      end

      S_DIV: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q != 6'd1) begin
          divRem_d = divTrial[32] ? divShift[31:0] : divTrial[31:0];
          divQuo_d = {divQuo_q[30:0], ~divTrial[32]};
        end else begin
          // Divide by zero yields all-ones quotient and the raw dividend as remainder.
          if (opB_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = opA_q;
          end else begin
            lo_d = quoFixed;
            hi_d = remFixed;
          end
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      op_q      <= OP_NONE;
      opA_q     <= 32'd0;
      opB_q     <= 32'd0;
      ppLow_q   <= 64'd0;
      ppCross_q <= 32'd0;
      prod_q    <= 64'd0;
      divQuo_q  <= 32'd0;
      divRem_q  <= 32'd0;
      divisor_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      ppLow_q   <= ppLow_d;
      ppCross_q <= ppCross_d;
      prod_q    <= prod_d;
      divQuo_q  <= divQuo_d;
      divRem_q  <= divRem_d;
      divisor_q <= divisor_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Busy is purely registered; the stall only combines it with current EX requests.
  assign hi              = hi_q;
  assign lo              = lo_q;
  assign muldiv_busy     = (state_q != S_IDLE);
  assign ex_muldiv_stall = muldiv_busy & (opValid | ex_read_hilo);

endmodule
